// File: rtl/timed_data_memory_if.sv
// Request/response bus between the core memory stage and timed_data_memory,
// plus the optional statistics counters (driven to 0 unless MEM_STATS_EN is defined).
interface timed_data_memory_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [31:0]           stat_reads;
  logic [31:0]           stat_writes;
  logic [31:0]           stat_errs;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  stat_reads, stat_writes, stat_errs
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output stat_reads, stat_writes, stat_errs
  );
endinterface

// File: rtl/timed_data_memory.sv
// Word-addressed data memory answering one request at a time after LATENCY cycles.
// Define MEM_STATS_EN to build the read/write/error statistics counters.
module timed_data_memory #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 4
) (
  input  logic                clk,
  input  logic                reset,
  timed_data_memory_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH_WORDS);
  localparam logic [7:0] CNT_START = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  load_ok_q, load_ok_d;
  logic [DATA_WIDTH-1:0] mem_rd_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic accept;
  logic commit;
  logic req_err;

  assign bus.req_ready = (state_q != BUSY);
  assign accept        = bus.req_valid && bus.req_ready;
  assign commit        = (state_q == BUSY) && (cnt_q == 8'd0);
  assign req_err       = (addr_q[1:0] != 2'b00) ||
                         ({2'b00, addr_q[ADDR_WIDTH-1:2]} >= DEPTH_LIMIT);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    load_ok_d = load_ok_q;
    case (state_q)
      IDLE, RESP: begin
        err_d     = 1'b0;
        load_ok_d = 1'b0;
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_START;
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d   = RESP;
          err_d     = req_err;
          load_ok_d = !wr_q && !req_err;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      load_ok_q <= load_ok_d;
    end
  end

  // NOTE: the array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (commit && !reset && !req_err) begin
      if (wr_q) begin
        mem[addr_q[IDX_W+1:2]] <= wdata_q;
      end else begin
        mem_rd_q <= mem[addr_q[IDX_W+1:2]];
      end
    end
  end

  // Response fields are masked outside RESP, so they drop to 0 on leaving it.
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = (state_q == RESP && load_ok_q) ? mem_rd_q : '0;
  assign bus.resp_err   = (state_q == RESP) && err_q;

`ifdef MEM_STATS_EN
  logic [31:0] stat_reads_q, stat_writes_q, stat_errs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      if (accept && bus.req_write)  stat_writes_q <= stat_writes_q + 32'd1;
      if (accept && !bus.req_write) stat_reads_q  <= stat_reads_q + 32'd1;
      if (commit && req_err)        stat_errs_q   <= stat_errs_q + 32'd1;
    end
  end

  assign bus.stat_reads  = stat_reads_q;
  assign bus.stat_writes = stat_writes_q;
  assign bus.stat_errs   = stat_errs_q;
`else
  assign bus.stat_reads  = '0;
  assign bus.stat_writes = '0;
  assign bus.stat_errs   = '0;
`endif
endmodule

// File: tb/tb_timed_data_memory.sv
// Scoreboard bench for timed_data_memory: one instance at LATENCY=4, one at LATENCY=1.
// Stimulus pushes expected responses; negedge monitors pop and compare data, error and cycle.
module tb_timed_data_memory;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16384;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] data1 [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timed_data_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  timed_data_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  timed_data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .LATENCY(4))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  timed_data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .LATENCY(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (mon_en) begin
      if (bus0.resp_valid === 1'b1) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut0_unexpected_resp: got resp_valid 1 expected no response");
        end else begin
          e = q0.pop_front();
          check("dut0_rdata", bus0.resp_rdata, e.rdata);
          check("dut0_err", 32'(bus0.resp_err), 32'(e.err));
          check("dut0_resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("dut0_idle_outs", bus0.resp_rdata | 32'(bus0.resp_err), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (mon_en) begin
      if (bus1.resp_valid === 1'b1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1_unexpected_resp: got resp_valid 1 expected no response");
        end else begin
          e = q1.pop_front();
          check("dut1_rdata", bus1.resp_rdata, e.rdata);
          check("dut1_err", 32'(bus1.resp_err), 32'(e.err));
          check("dut1_resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic issue0(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit expect_resp);
    exp_t e;
    int   waited = 0;
    bus0.req_valid = 1'b1;
    bus0.req_write = wr;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    while (bus0.req_ready !== 1'b1) begin
      if (waited == 50) begin
        checks++;
        errors++;
        $display("FAIL dut0_ready_timeout: got req_ready %b expected 1", bus0.req_ready);
        bus0.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    if (expect_resp) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + 1 + 4;
      q0.push_back(e);
    end
    @(negedge clk);
    bus0.req_valid = 1'b0;
  endtask

  task automatic issue1(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata);
    exp_t e;
    int   waited = 0;
    bus1.req_valid = 1'b1;
    bus1.req_write = wr;
    bus1.req_addr  = addr;
    bus1.req_wdata = wdata;
    while (bus1.req_ready !== 1'b1) begin
      if (waited == 50) begin
        checks++;
        errors++;
        $display("FAIL dut1_ready_timeout: got req_ready %b expected 1", bus1.req_ready);
        bus1.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    e.rdata = exp_rdata;
    e.err   = 1'b0;
    e.cyc   = cyc + 1 + 1;
    q1.push_back(e);
    @(negedge clk);
    bus1.req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (q0.size() != 0 || q1.size() != 0) begin
      if (waited == 100) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d/%0d pending responses expected 0/0",
                 q0.size(), q1.size());
        q0.delete();
        q1.delete();
        break;
      end
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    data1[0] = 32'h1111_0000;
    data1[1] = 32'h2222_0001;
    data1[2] = 32'h3333_0002;
    reset = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_req_ready", 32'(bus0.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("rst_resp_rdata", bus0.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus0.resp_err), 32'd0);
    check("rst_stat_reads", bus0.stat_reads, 32'd0);
    check("rst_dut1_ready", 32'(bus1.req_ready), 32'd1);
    mon_en = 1'b1;

    // Store then a load accepted in the store's RESP cycle (read-after-write).
    issue0(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    issue0(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    // Misaligned, out-of-range and misaligned-store errors.
    issue0(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
    issue0(1'b0, 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1, 1'b1);
    issue0(1'b1, 32'h11, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
    drain();
    check("mem_word4_kept", dut0.mem[4], 32'hDEAD_BEEF);

    // Store aborted by a reset on the edge before its commit edge.
    issue0(1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0, 1'b1);
    drain();
    issue0(1'b1, 32'h20, 32'h55AA_55AA, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 32'(bus0.req_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("abort_mem_word8", dut0.mem[8], 32'h1111_1111);

    // Statistics sequence since the last reset: 2 stores, 3 loads, 1 misaligned load.
    issue0(1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, 1'b1);
    issue0(1'b1, 32'h24, 32'hA5A5_0001, 32'h0, 1'b0, 1'b1);
    issue0(1'b1, 32'h28, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1);
    issue0(1'b0, 32'h24, 32'h0, 32'hA5A5_0001, 1'b0, 1'b1);
    issue0(1'b0, 32'h28, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
    issue0(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
    drain();
`ifdef MEM_STATS_EN
    check("stat_reads", bus0.stat_reads, 32'd4);
    check("stat_writes", bus0.stat_writes, 32'd2);
    check("stat_errs", bus0.stat_errs, 32'd1);
`else
    check("stat_reads", bus0.stat_reads, 32'd0);
    check("stat_writes", bus0.stat_writes, 32'd0);
    check("stat_errs", bus0.stat_errs, 32'd0);
`endif

    // LATENCY=1 instance: fill three words, then hold req_valid high for three loads.
    for (int i = 0; i < 3; i++) issue1(1'b1, 32'(i * 4), data1[i], 32'h0);
    drain();
    n = 0;
    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b0;
    bus1.req_addr  = 32'h0;
    for (int i = 0; i < 6; i++) begin
      check("dut1_ready_pattern", 32'(bus1.req_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (bus1.req_ready === 1'b1 && n < 3) begin
        exp_t e;
        bus1.req_addr = 32'(n * 4);
        e.rdata = data1[n];
        e.err   = 1'b0;
        e.cyc   = cyc + 2;
        q1.push_back(e);
        n++;
      end
      @(negedge clk);
    end
    bus1.req_valid = 1'b0;
    check("dut1_accepts", 32'(n), 32'd3);
    drain();
`ifdef MEM_STATS_EN
    check("dut1_stat_reads", bus1.stat_reads, 32'd3);
    check("dut1_stat_writes", bus1.stat_writes, 32'd3);
`else
    check("dut1_stat_reads", bus1.stat_reads, 32'd0);
    check("dut1_stat_writes", bus1.stat_writes, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timed_data_memory.md
Name: timed_data_memory

Overview:
- Word-addressed data memory with a fixed, parameterised access latency.
- Sits directly downstream of the CPU core's memory stage: the core issues one load/store request at a time through a valid/ready handshake, and the block returns a single-cycle response.
- Replaces the zero-latency memory so the core's stall logic and the testbench cycle count (total cycle at halt) can be exercised under realistic timing.
- Contents are inspectable hierarchically through the internal array `mem`.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr.
- DATA_WIDTH, 32, word width.
- DEPTH_WORDS, 16384, number of words in `mem`.
- LATENCY, 4, cycles from acceptance edge to response (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data.
- resp_valid  output  1  response pulse, exactly one cycle.
- resp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.
- stat_reads  output  32  accepted loads (MEM_STATS_EN only, else 0).
- stat_writes  output  32  accepted stores (MEM_STATS_EN only, else 0).
- stat_errs  output  32  error responses (MEM_STATS_EN only, else 0).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`, sampled at the rising edge of clk.
- Reset state:
  - state=IDLE, counter=0.
  - req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - stat_* = 0.
  - `mem` contents are not reset.
- States: IDLE, BUSY, RESP.
- Ready rule: req_ready=1 in IDLE and RESP, 0 in BUSY. Acceptance = req_valid & req_ready at a rising edge.
- On acceptance:
  - Latch write flag, address and wdata.
  - Go to BUSY with counter = LATENCY-1.
- BUSY:
  - Each edge: if counter != 0, decrement counter.
  - Else commit and go to RESP.
- Commit edge:
  - Store: writes `mem[addr>>2]` unless the request is in error.
  - Load: captures `mem[addr>>2]` into resp_rdata.
- RESP: resp_valid=1 for exactly this cycle, with resp_rdata/resp_err held stable. There is no backpressure on the response.
- Timing:
  - Response is visible in the cycle after the LATENCY-th edge following the acceptance edge.
  - LATENCY=1 → resp_valid one cycle after acceptance.
  - Back-to-back period = LATENCY+1 cycles.
- Leaving RESP:
  - If a new request is accepted in RESP → BUSY, else → IDLE.
  - resp_valid, resp_rdata and resp_err return to 0.
- Error condition: addr[1:0] != 0, or (addr>>2) >= DEPTH_WORDS.
  - Response: resp_err=1, resp_rdata=0, no write.
  - Latency is unchanged.
- Read-after-write: a load accepted in the RESP cycle of a store to the same address returns the new data.
- Request inputs are ignored while in BUSY.
- Reset mid-operation: any in-flight request is aborted. If reset arrives before the commit edge, no write occurs; no response is produced.
- Address bits above the word index beyond DEPTH_WORDS cause an error; they do not wrap.

Optional Feature:
- Macro: MEM_STATS_EN.
- Defined:
  - stat_reads and stat_writes increment by 1 on the acceptance edge of a load or store respectively (errors included).
  - stat_errs increments on the commit edge of an erroring request.
  - Counters are 32-bit and wrap modulo 2^32.
  - Cleared by reset.
- Undefined: counter logic is absent; stat_* ports are tied to 0.

Test Plan:
- Reset for 2 cycles, then release → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- LATENCY=4: store addr 0x10, data 0xDEADBEEF accepted at edge T; load 0x10 accepted in the RESP cycle → store resp_valid after edge T+4; load returns 0xDEADBEEF with resp_valid after edge T+9.
- Load addr 0x13 (misaligned) and load addr DEPTH_WORDS*4 → resp_err=1, resp_rdata=0, same latency; `mem` unchanged.
- Hold req_valid=1 continuously with 3 loads at LATENCY=1 → exactly one acceptance every 2 cycles; req_ready=0 in BUSY cycles; 3 resp_valid pulses.
- Store 0x55AA55AA to 0x20, assert reset on the edge before commit, then load 0x20 → old value returned; no resp_valid for the aborted store.
- MEM_STATS_EN defined: 2 stores, 3 loads, 1 misaligned load → stat_writes=2, stat_reads=4, stat_errs=1; without the macro all stat_* read 0.
